// File: rtl/mem_access_pkg.sv
// Shared definitions for the M-stage data memory access unit:
// RV32I load/store funct3 codes, FSM state encoding, byte-strobe patterns
// and the misaligned-access predicate.
package mem_access_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned STRB_W_BITS = XLEN / 8;

  // RV32I funct3 encodings for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size as carried by funct3[1:0]; 2'b10 and 2'b11 both mean word
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [STRB_W_BITS-1:0] STRB_NONE = 4'b0000;
  localparam logic [STRB_W_BITS-1:0] STRB_B0   = 4'b0001;
  localparam logic [STRB_W_BITS-1:0] STRB_HLO  = 4'b0011;
  localparam logic [STRB_W_BITS-1:0] STRB_HHI  = 4'b1100;
  localparam logic [STRB_W_BITS-1:0] STRB_W    = 4'b1111;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for the data memory access unit.
//   st_size/st_off/st_data  -> st_wdata_c/st_wstrb_c : store lane replication + byte enables
//   ld_funct3/ld_off/ld_rdata -> ld_data_c           : load lane select + sign/zero extension
module load_store_align
  import mem_access_pkg::*;
(
  input  logic [1:0]             st_size,
  input  logic [1:0]             st_off,
  input  logic [XLEN-1:0]        st_data,
  output logic [XLEN-1:0]        st_wdata_c,
  output logic [STRB_W_BITS-1:0] st_wstrb_c,
  input  logic [2:0]             ld_funct3,
  input  logic [1:0]             ld_off,
  input  logic [XLEN-1:0]        ld_rdata,
  output logic [XLEN-1:0]        ld_data_c
);

  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;

  // Store: replicate the low byte/half into every lane so any strobe lines up
  always_comb begin
    st_wdata_c = st_data;
    st_wstrb_c = STRB_W;
    case (st_size)
      SZ_B: begin
        st_wdata_c = {4{st_data[7:0]}};
        st_wstrb_c = STRB_B0 << st_off;
      end
      SZ_H: begin
        st_wdata_c = {2{st_data[15:0]}};
        st_wstrb_c = st_off[1] ? STRB_HHI : STRB_HLO;
      end
      default: ;
    endcase
  end

  // Load: pick the lane then extend; unknown funct3 falls through to a word
  always_comb begin
    ld_byte_c = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half_c = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      F3_BU:   ld_data_c = {24'h000000, ld_byte_c};
      F3_H:    ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      F3_HU:   ld_data_c = {16'h0000, ld_half_c};
      default: ld_data_c = ld_rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// M-stage data memory access controller.
// Accepts a load/store from the E->M registers, runs one valid/ready request
// on the data bus (waiting for the read response on loads), and returns the
// extended load result in ReadDataM. StallM freezes the pipeline meanwhile.
//   clk, rst (async, active-low)
//   ALUResultM, WriteDataM, MemWriteM, MemReadM, Funct3M : access from M stage
//   ReadDataM, StallM, MisalignM                          : to pipeline
//   mem_req_* / mem_rsp_*                                 : data memory bus
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (no bus request, MisalignM pulse, loads return 0); otherwise MisalignM is 0
// and the low address bits are simply truncated.
module data_mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        ALUResultM,
  input  logic [XLEN-1:0]        WriteDataM,
  input  logic                   MemWriteM,
  input  logic                   MemReadM,
  input  logic [2:0]             Funct3M,
  output logic [XLEN-1:0]        ReadDataM,
  output logic                   StallM,
  output logic                   MisalignM,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_we,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [XLEN-1:0]        mem_req_wdata,
  output logic [STRB_W_BITS-1:0] mem_req_wstrb,
  input  logic                   mem_rsp_valid,
  input  logic [XLEN-1:0]        mem_rsp_rdata
);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic [STRB_W_BITS-1:0] wstrb_q, wstrb_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [1:0]             off_q, off_d;
  logic                   req_valid_q, req_valid_d;
  logic [XLEN-1:0]        rdata_q, rdata_d;
  logic                   misalign_q, misalign_d;

  logic                   access_c;
  logic                   misalign_c;
  logic [XLEN-1:0]        st_wdata_c;
  logic [STRB_W_BITS-1:0] st_wstrb_c;
  logic [XLEN-1:0]        ld_data_c;

  assign access_c = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = is_misaligned(Funct3M[1:0], ALUResultM[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  load_store_align u_align (
    .st_size    (Funct3M[1:0]),
    .st_off     (ALUResultM[1:0]),
    .st_data    (WriteDataM),
    .st_wdata_c (st_wdata_c),
    .st_wstrb_c (st_wstrb_c),
    .ld_funct3  (funct3_q),
    .ld_off     (off_q),
    .ld_rdata   (mem_rsp_rdata),
    .ld_data_c  (ld_data_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a simultaneous read+write is handled as a store via we_q
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (access_c) state_d = misalign_c ? ST_DONE : ST_REQ;
      ST_REQ:      if (req_valid_q && mem_req_ready) state_d = we_q ? ST_DONE : ST_WAIT_RSP;
      ST_WAIT_RSP: if (mem_rsp_valid) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; request fields only load in IDLE so they
  // stay stable for the whole REQ phase
  always_comb begin
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    misalign_d  = 1'b0;
    req_valid_d = (state_d == ST_REQ);
    StallM      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        StallM = access_c;
        if (access_c) begin
          if (misalign_c) begin
            misalign_d = 1'b1;
            if (!MemWriteM) rdata_d = '0;
          end else begin
            addr_d   = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
            we_d     = MemWriteM;
            wdata_d  = MemWriteM ? st_wdata_c : '0;
            wstrb_d  = MemWriteM ? st_wstrb_c : STRB_NONE;
            funct3_d = Funct3M;
            off_d    = ALUResultM[1:0];
          end
        end
      end
      ST_REQ:      StallM = 1'b1;
      ST_WAIT_RSP: begin
        StallM = 1'b1;
        if (mem_rsp_valid) rdata_d = ld_data_c;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= STRB_NONE;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      req_valid_q <= 1'b0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      req_valid_q <= req_valid_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign ReadDataM     = rdata_q;
  assign MisalignM     = misalign_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit: expected bus requests and load
// results are queued when an access is driven and compared as they appear.
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM;
  logic        MemWriteM, MemReadM;
  logic [2:0]  Funct3M;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  always #5 clk = ~clk;

  data_mem_access_unit dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .Funct3M(Funct3M),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_rd_now = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit misal(input logic [2:0] f3, input logic [1:0] off);
    return (int'(off) % nbytes(f3)) != 0;
  endfunction

  // Byte-lane view of a store: lane i carries store byte (i mod size)
  function automatic req_t model_req(input logic we, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    int   n    = nbytes(f3);
    int   base = (int'(a[1:0]) / n) * n;
    r.we    = we;
    r.addr  = a & 32'hFFFF_FFFC;
    r.wdata = '0;
    r.wstrb = '0;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        r.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        if (i >= base && i < base + n) r.wstrb[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    int          n    = nbytes(f3);
    int          base = (int'(off) / n) * n;
    logic [31:0] v    = rdata >> (8 * base);
    bit          sgn  = !f3[2];
    if (n == 1) return sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
    if (n == 2) return sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
    return v;
  endfunction

  // Drive one access, play memory (ready after rdy_dly valid cycles, response in
  // the rsp_wait-th WAIT cycle) and check request fields, stall length and result
  task automatic run_access(input string tag, input logic w, input logic r,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input int rdy_dly, input int rsp_wait, input logic [31:0] rdata);
    bit          trap = TRAP && misal(f3, a[1:0]);
    int          exp_stall;
    int          stall = 0;
    int          vcyc = 0;
    int          k = -1;
    int          cyc = 0;
    bit          done = 1'b0;
    logic [31:0] exp_rd;
    req_t        er;

    if (!trap) req_q.push_back(model_req(w, f3, a, wd));
    if (!w) rd_q.push_back(trap ? 32'h0 : model_load(f3, a[1:0], rdata));
    if (trap)   exp_stall = 1;
    else if (w) exp_stall = 2 + rdy_dly;
    else        exp_stall = 2 + rdy_dly + rsp_wait;

    @(posedge clk); #1;
    MemWriteM = w; MemReadM = r; Funct3M = f3; ALUResultM = a; WriteDataM = wd;

    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      mem_rsp_valid = 1'b0;
      if (StallM) stall++;
      if (!StallM && stall > 0) begin
        done = 1'b1;
        chk({tag, "_stall_cycles"}, stall, exp_stall);
        chk({tag, "_misalign"}, MisalignM, trap);
        if (!w) begin
          exp_rd = rd_q.pop_front();
          exp_rd_now = exp_rd;
        end
        chk({tag, "_rdata"}, ReadDataM, exp_rd_now);
        MemWriteM = 1'b0; MemReadM = 1'b0; mem_req_ready = 1'b0;
      end else begin
        if (k >= 0) begin
          k++;
          if (!w && k == rsp_wait) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
          end
        end
        if (mem_req_valid) begin
          vcyc++;
          if (req_q.size() == 0) begin
            chk({tag, "_unexpected_req"}, mem_req_valid, 1'b0);
            mem_req_ready = 1'b1;
          end else begin
            er = req_q[0];
            chk({tag, "_we"}, mem_req_we, er.we);
            chk({tag, "_addr"}, mem_req_addr, er.addr);
            chk({tag, "_wdata"}, mem_req_wdata, er.wdata);
            chk({tag, "_wstrb"}, mem_req_wstrb, er.wstrb);
            mem_req_ready = (vcyc > rdy_dly);
            if (mem_req_ready) begin
              void'(req_q.pop_front());
              k = 0;
            end
          end
        end else begin
          mem_req_ready = 1'b0;
        end
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, done, 1'b1);
      MemWriteM = 1'b0; MemReadM = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    end
    if (trap) begin
      @(negedge clk);
      chk({tag, "_misalign_pulse_end"}, MisalignM, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    ALUResultM = '0; WriteDataM = '0; MemWriteM = 1'b0; MemReadM = 1'b0; Funct3M = 3'b000;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", mem_req_valid, 1'b0);
    chk("rst_we", mem_req_we, 1'b0);
    chk("rst_addr", mem_req_addr, 32'h0);
    chk("rst_wdata", mem_req_wdata, 32'h0);
    chk("rst_wstrb", mem_req_wstrb, 4'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_misalign", MisalignM, 1'b0);
    chk("rst_stall", StallM, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    run_access("sw",       1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    run_access("sb",       1'b1, 1'b0, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0);
    run_access("sh_hi",    1'b1, 1'b0, 3'b001, 32'h102, 32'h1234ABCD, 1, 0, 32'h0);
    run_access("lb",       1'b0, 1'b1, 3'b000, 32'h102, 32'h0,        3, 4, 32'h0080FF00);
    run_access("lhu",      1'b0, 1'b1, 3'b101, 32'h102, 32'h0,        0, 1, 32'hBEEF1234);
    run_access("lh",       1'b0, 1'b1, 3'b001, 32'h102, 32'h0,        0, 1, 32'hBEEF1234);
    run_access("lbu",      1'b0, 1'b1, 3'b100, 32'h101, 32'h0,        0, 2, 32'h00008000);
    run_access("lw",       1'b0, 1'b1, 3'b010, 32'h200, 32'h0,        2, 1, 32'h12345678);
    run_access("lw_undef", 1'b0, 1'b1, 3'b111, 32'h204, 32'h0,        0, 1, 32'h80000001);
    run_access("sw_rw",    1'b1, 1'b1, 3'b010, 32'h104, 32'h0BADF00D, 0, 0, 32'h0);
    run_access("lw_mis",   1'b0, 1'b1, 3'b010, 32'h101, 32'h0,        0, 1, 32'hCAFEF00D);
    run_access("lh_after", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0,        0, 1, 32'hBEEF1234);

    // Reset while waiting for a load response, then a late response
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_req_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rstmid_wait_stall", StallM, 1'b1);
    rst = 1'b0;
    #1;
    chk("rstmid_valid", mem_req_valid, 1'b0);
    chk("rstmid_rdata", ReadDataM, 32'h0);
    chk("rstmid_addr", mem_req_addr, 32'h0);
    MemReadM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_rdata", ReadDataM, 32'h0);
    chk("late_rsp_stall", StallM, 1'b0);
    chk("late_rsp_valid", mem_req_valid, 1'b0);

    chk("req_queue_drained", req_q.size(), 32'h0);
    chk("rd_queue_drained", rd_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Memory-access controller in the M stage, between the execute→memory pipeline registers and the memory→writeback pipeline registers.
- Drives a valid/ready data-memory bus with variable response latency, and aligns store data and byte strobes.
- Sign- or zero-extends load data into ReadDataM, which the M→W register captures.
- Asserts StallM to freeze the pipeline while a bus transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of mem_req_addr. ALUResultM[ADDR_WIDTH-1:0] is used.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store data, unaligned, in the low lanes
- MemWriteM  in  1  store in M
- MemReadM  in  1  load in M
- Funct3M  in  3  access size/sign (RV32I encoding)
- ReadDataM  out  32  extended load result, registered
- StallM  out  1  freeze F/D/E/M pipeline registers
- MisalignM  out  1  one-cycle misaligned-access flag (see Optional Feature)
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write
- mem_req_addr  out  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2],2'b00}
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wstrb  out  4  byte enables
- mem_rsp_valid  in  1  read data valid
- mem_rsp_rdata  in  32  raw read word

Behaviour:
- Reset (rst=0, async): state=IDLE. mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wstrb=0, ReadDataM=0, MisalignM=0. StallM=0 while no access is presented.
- access = MemReadM | MemWriteM. If both are high, treat as a store and ignore the read.
- FSM: IDLE, REQ, WAIT_RSP, DONE.
  - IDLE: if access, register addr/we/wdata/wstrb/funct3/byte-offset and go to REQ; otherwise stay.
  - REQ: mem_req_valid=1. Request fields stay stable until mem_req_ready. On valid&ready: store → DONE; load → WAIT_RSP.
  - WAIT_RSP: on mem_rsp_valid, capture the extended data into ReadDataM and go to DONE. mem_rsp_valid is ignored in every other state.
  - DONE: one cycle with StallM=0 so the pipeline advances, then IDLE.
- StallM = (IDLE & access) | REQ | WAIT_RSP, combinational. Minimum stall cycles: store 2, load 3 (ready and rsp each immediate).
- Store strobes by Funct3M[1:0] and addr[1:0]:
  - SB: wstrb = 1<<addr[1:0]; wdata = byte replicated ×4.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated ×2.
  - SW: wstrb = 4'b1111.
  - Funct3M[2] is ignored for stores.
- Load extract:
  - LB/LBU: lane addr[1:0].
  - LH/LHU: lane addr[1].
  - LW: full word.
  - Sign-extend for 000/001, zero-extend for 100/101.
  - Undefined funct3 011/110/111 is treated as LW.
- ReadDataM holds its value until the next load response (or a trap, see below). Stores do not modify it.
- Reset mid-transaction: immediate return to IDLE and mem_req_valid drops. A late mem_rsp_valid is ignored.
- Back-to-back accesses: the next instruction arrives in M the cycle after DONE, and IDLE accepts it that cycle.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: a misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) is detected in IDLE.
  - No bus request is issued.
  - FSM goes IDLE→DONE with StallM=1 for that one cycle.
  - MisalignM=1 in DONE.
  - Load: ReadDataM is set to 0. Store: suppressed.
- Undefined: MisalignM is tied to 0. Misaligned accesses are performed with the low address bits truncated (LH uses addr[1] only; LW ignores addr[1:0]).

Decomposition:
- Package mem_access_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), the 2-bit FSM state encoding, and strobe constants.
- Sub-module load_store_align (combinational): store lane replication and wstrb; load lane select and extension. The FSM and registers stay in the top module.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ready=1 → one request with we=1, addr 0x100, wstrb 1111; StallM high for 2 cycles.
- SB addr 0x103, data 0x000000A5 → wstrb 1000, wdata 0xA5A5A5A5.
- LB addr 0x102, rdata 0x0080FF00, rsp 4 cycles after accept → ReadDataM 0xFFFFFF80; StallM held through WAIT_RSP; mem_req_valid holds 3 cycles under ready=0 with stable fields.
- LHU addr 0x102, rdata 0xBEEF1234 → ReadDataM 0x0000BEEF; LH at same address → 0xFFFFBEEF.
- rst=0 asserted in WAIT_RSP, then a late mem_rsp_valid → mem_req_valid=0 and ReadDataM=0 immediately; the late response is ignored.
- With MISALIGN_TRAP_EN, LW addr 0x101 → no mem_req_valid, MisalignM pulses for 1 cycle, ReadDataM=0. Without the macro → a read at 0x100 is issued.
